nor_array_checker: RTL and testbench

NOR_ARRAY_CHECKER -- requirements
Module: nor_array_checker

---
 rtl/nor_chk_pkg.sv | 19 +
 rtl/nor_array_checker_nor4_ref.sv | 15 +
 rtl/nor_array_checker.sv | 158 +++++++++++++++
 tb/tb_nor_array_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nor_chk_pkg.sv
// nor_chk_pkg: shared types and sizes for the NOR array checker.
//   state_t   - checker FSM states
//   NUM_PAIRS - number of 2-input NOR gates under test
//   VEC_W     - width of the stimulus vector (two inputs per pair)
//   ERR_W     - width of the failing-vector counter (0..256)
package nor_chk_pkg;

    localparam int unsigned NUM_PAIRS = 4;
    localparam int unsigned VEC_W     = 8;
    localparam int unsigned ERR_W     = 9;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/nor_array_checker_nor4_ref.sv
// nor4_ref: combinational golden model of the NOR array.
//   stim     in  [VEC_W-1:0]     pair k inputs are stim[2k] and stim[2k+1]
//   expected out [NUM_PAIRS-1:0] expected[k] = ~(stim[2k] | stim[2k+1])
module nor4_ref
    import nor_chk_pkg::*;
(
    input  logic [VEC_W-1:0]     stim,
    output logic [NUM_PAIRS-1:0] expected
);

    for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_pair
        assign expected[k] = ~(stim[2*k] | stim[2*k+1]);
    end

endmodule

// File: rtl/nor_array_checker.sv
// nor_array_checker: exhaustive sweep of all 256 input vectors through a
// 4-pair NOR array, counting vectors whose response differs from the model.
//   Parameter SETTLE (1..15): cycles stim is held before resp is sampled.
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   start a sweep (only honoured in IDLE)
//   stim     out  [7:0] vector driven to the array
//   resp     in   [3:0] array response, resp[k] for pair k
//   busy     out  high while a sweep is in progress (through DONE)
//   done     out  one-cycle pulse at sweep completion
//   pass     out  sweep finished with err_cnt == 0; held until next start
//   err_cnt  out  [8:0] failing vectors in the last/current sweep
// Optional macro NOR_CHK_FIRSTFAIL_EN adds:
//   first_fail_vec   out  [7:0] first failing vector of the sweep
//   first_fail_valid out  first_fail_vec holds a captured vector
module nor_array_checker
    import nor_chk_pkg::*;
#(
    parameter int unsigned SETTLE = 1
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [VEC_W-1:0] stim,
    input  logic [NUM_PAIRS-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt
`ifdef NOR_CHK_FIRSTFAIL_EN
    ,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic             first_fail_valid
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t               state;
    state_t               state_nxt;
    logic [VEC_W-1:0]     vec;
    logic [3:0]           settle_cnt;
    logic [ERR_W-1:0]     err_q;
    logic                 pass_q;
    logic [NUM_PAIRS-1:0] expected;
    logic                 start_acc;
    logic                 settle_done;
    logic                 last_vec;
    logic                 mismatch;

    nor4_ref u_ref (
        .stim     (vec),
        .expected (expected)
    );

    always_comb begin
        start_acc   = (state == IDLE) && start;
        settle_done = (settle_cnt == SETTLE_LAST);
        last_vec    = (vec == '1);
        // Any differing bit fails the whole vector exactly once.
        mismatch    = (resp != expected);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = DRIVE;
            DRIVE:   if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector, settle counter, error counter and pass flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_q      <= '0;
            pass_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        err_q      <= '0;
                        pass_q     <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_done ? '0 : settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                    // vec stops at 0xFF so stim holds it in IDLE afterwards.
                    if (last_vec) begin
                        // Includes the final vector's result so pass is
                        // already valid while done is high.
                        pass_q <= (err_q == '0) && !mismatch;
                    end else begin
                        vec <= vec + VEC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        stim    = vec;
        busy    = (state != IDLE);
        done    = (state == DONE);
        pass    = pass_q;
        err_cnt = err_q;
    end

`ifdef NOR_CHK_FIRSTFAIL_EN
    logic [VEC_W-1:0] ff_vec;
    logic             ff_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec   <= '0;
            ff_valid <= 1'b0;
        end else if (start_acc) begin
            ff_vec   <= '0;
            ff_valid <= 1'b0;
        end else if ((state == SAMPLE) && mismatch && !ff_valid) begin
            ff_vec   <= vec;
            ff_valid <= 1'b1;
        end
    end

    always_comb begin
        first_fail_vec   = ff_vec;
        first_fail_valid = ff_valid;
    end
`else
    // Without first-fail capture the sweep result is err_cnt and pass only.
`endif

endmodule

// File: tb/tb_nor_array_checker.sv
// Directed self-checking bench for nor_array_checker (SETTLE=1 and SETTLE=3).
module tb_nor_array_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       start3 = 1'b0;
    logic [7:0] stim, stim3;
    logic [3:0] resp, resp3;
    logic       busy, done, pass;
    logic       busy3, done3, pass3;
    logic [8:0] err_cnt, err_cnt3;
`ifdef NOR_CHK_FIRSTFAIL_EN
    logic [7:0] ffv, ffv3;
    logic       ffvalid, ffvalid3;
`endif

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 good array, 1 resp[2] stuck 0, 2 resp[0] stuck 1

    always #5 clk = ~clk;

    nor_array_checker #(.SETTLE(1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stim    (stim),
        .resp    (resp),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .err_cnt (err_cnt)
`ifdef NOR_CHK_FIRSTFAIL_EN
        ,
        .first_fail_vec   (ffv),
        .first_fail_valid (ffvalid)
`endif
    );

    nor_array_checker #(.SETTLE(3)) dut3 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start3),
        .stim    (stim3),
        .resp    (resp3),
        .busy    (busy3),
        .done    (done3),
        .pass    (pass3),
        .err_cnt (err_cnt3)
`ifdef NOR_CHK_FIRSTFAIL_EN
        ,
        .first_fail_vec   (ffv3),
        .first_fail_valid (ffvalid3)
`endif
    );

    function automatic logic [3:0] nor_model(input logic [7:0] s);
        return {~(s[7] | s[6]), ~(s[5] | s[4]), ~(s[3] | s[2]), ~(s[1] | s[0])};
    endfunction

    always_comb begin
        resp = nor_model(stim);
        if (mode == 1)      resp[2] = 1'b0;
        else if (mode == 2) resp[0] = 1'b1;
    end

    always_comb resp3 = nor_model(stim3);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int dones;
        int t1;
        int t2;
        bit pulsed;

        // Reset state
        tick();
        tick();
        check("rst_stim", stim, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_cnt, 9'd0);
        check("rst_stim3", stim3, 8'h00);
        rst_n = 1'b1;
        tick();

        // Good array: 256 vectors x 2 cycles
        mode = 0;
        pulse_start();
        check("good_busy", busy, 1'b1);
        check("good_stim0", stim, 8'h00);
        wait_done(3000, n);
        check("good_len", n, 512);
        check("good_err", err_cnt, 9'd0);
        tick();
        check("good_done_pulse", done, 1'b0);
        check("good_idle", busy, 1'b0);
        check("good_pass", pass, 1'b1);
        check("good_stim_hold", stim, 8'hFF);
`ifdef NOR_CHK_FIRSTFAIL_EN
        check("good_ff_valid", ffvalid, 1'b0);
`endif

        // resp[2] stuck 0: pair 2 expects 1 only when stim[5:4]==0 -> 64 fails
        mode = 1;
        pulse_start();
        check("s0_pass_clr", pass, 1'b0);
        check("s0_err_clr", err_cnt, 9'd0);
        wait_done(3000, n);
        check("s0_len", n, 512);
        tick();
        check("s0_err", err_cnt, 9'd64);
        check("s0_pass", pass, 1'b0);
`ifdef NOR_CHK_FIRSTFAIL_EN
        check("s0_ffv", ffv, 8'h00);
        check("s0_ffvalid", ffvalid, 1'b1);
`endif

        // resp[0] stuck 1: pair 0 expects 0 when stim[1:0]!=0 -> 192 fails
        mode = 2;
        pulse_start();
`ifdef NOR_CHK_FIRSTFAIL_EN
        check("s1_ffvalid_clr", ffvalid, 1'b0);
`endif
        wait_done(3000, n);
        tick();
        check("s1_err", err_cnt, 9'd192);
        check("s1_pass", pass, 1'b0);
`ifdef NOR_CHK_FIRSTFAIL_EN
        check("s1_ffv", ffv, 8'h01);
        check("s1_ffvalid", ffvalid, 1'b1);
`endif

        // start pulsed mid-sweep at vec 0x40 is ignored
        mode = 0;
        pulse_start();
        n = 0;
        pulsed = 1'b0;
        while (done !== 1'b1 && n < 3000) begin
            if (!pulsed && stim == 8'h40) begin
                start = 1'b1;
                pulsed = 1'b1;
            end
            tick();
            start = 1'b0;
            n++;
        end
        check("mid_pulsed", pulsed, 1'b1);
        check("mid_len", n, 512);
        check("mid_err", err_cnt, 9'd0);
        dones = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("mid_no_extra_done", dones, 0);
        check("mid_idle", busy, 1'b0);

        // start held high: DONE ignores it, following IDLE cycle restarts
        start = 1'b1;
        tick();
        check("hold_busy", busy, 1'b1);
        wait_done(3000, n);
        check("hold_len", n, 512);
        tick();
        check("hold_idle_gap", busy, 1'b0);
        tick();
        check("hold_restart", busy, 1'b1);
        check("hold_stim0", stim, 8'h00);
        start = 1'b0;

        // Reset mid-sweep at vec 0x80
        mode = 1;
        n = 0;
        while (stim !== 8'h80 && n < 3000) begin
            tick();
            n++;
        end
        check("abort_reach80", stim, 8'h80);
        rst_n = 1'b0;
        #1;
        check("abort_stim", stim, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_err", err_cnt, 9'd0);
        check("abort_done", done, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        mode = 0;
        pulse_start();
        check("abort_restart_stim", stim, 8'h00);
        wait_done(3000, n);
        check("abort_rerun_len", n, 512);
        tick();
        check("abort_rerun_pass", pass, 1'b1);
        check("abort_rerun_err", err_cnt, 9'd0);

        // SETTLE=3: each vector lasts 3 DRIVE + 1 SAMPLE cycles
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        t1 = -1;
        t2 = -1;
        while (done3 !== 1'b1 && n < 6000) begin
            tick();
            n++;
            if (t1 < 0 && stim3 == 8'h01) t1 = n;
            if (t2 < 0 && stim3 == 8'h02) t2 = n;
        end
        check("s3_vec1_at", t1, 4);
        check("s3_vec2_at", t2, 8);
        check("s3_len", n, 1024);
        tick();
        check("s3_pass", pass3, 1'b1);
        check("s3_err", err_cnt3, 9'd0);
        check("s3_stim_hold", stim3, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
